// File: rtl/xeng_mac_ctrl_pkg.sv
// Shared types for the X-engine MAC controller: FSM states and tag field layout.
// Tag layout (LSB first): last, first, baseline index, then the valid bit at the top.
package xeng_mac_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int TAG_LAST_POS  = 0;
  localparam int TAG_FIRST_POS = 1;
  localparam int TAG_BL_LSB    = 2;

  function automatic int tag_width(input int n_bl_bits);
    return n_bl_bits + 3;
  endfunction

  function automatic int tag_vld_pos(input int n_bl_bits);
    return n_bl_bits + 2;
  endfunction

endpackage

// File: rtl/xeng_tag_delay.sv
// Tag shift register matched to the MAC chain; latency DEPTH cycles, no backpressure.
// flush clears every valid bit at the edge, including the tag shifting in.
module xeng_tag_delay
  import xeng_mac_ctrl_pkg::*;
#(
  parameter int N_BL_BITS = 4,
  parameter int DEPTH     = 6,
  parameter int TAG_W     = tag_width(N_BL_BITS),
  parameter int VLD_POS   = tag_vld_pos(N_BL_BITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [TAG_W-1:0] tag_in,
  output logic [TAG_W-1:0] tag_out
);

  logic [TAG_W-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) stage[i][VLD_POS] <= 1'b0;
      end
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/xeng_mac_ctrl.sv
// Baseline sequencer and per-baseline integrator behind the X-engine MAC chain.
// dout follows an accept by MAC_LATENCY+1 cycles; no backpressure, results are pushed out.
module xeng_mac_ctrl
  import xeng_mac_ctrl_pkg::*;
#(
  parameter int BITWIDTH     = 4,
  parameter int N_INPUT_BITS = 3,
  parameter int OUTPUT_WIDTH = 2*BITWIDTH+1+N_INPUT_BITS,
  parameter int N_BL_BITS    = 4,
  parameter int ACC_LEN_BITS = 8,
  parameter int ACC_WIDTH    = 32,
  parameter int MAC_LATENCY  = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sync,
  input  logic [ACC_LEN_BITS-1:0]   acc_len,
  input  logic                      in_valid,
  output logic [N_BL_BITS-1:0]      bl_idx,
  input  logic [2*OUTPUT_WIDTH-1:0] mac_ab,
  output logic [2*ACC_WIDTH-1:0]    dout,
  output logic                      dout_valid,
  output logic [N_BL_BITS-1:0]      dout_bl,
  output logic                      sync_err,
  output logic                      running
);

  localparam int N_BL    = 1 << N_BL_BITS;
  localparam int TAG_W   = tag_width(N_BL_BITS);
  localparam int TAG_VLD = tag_vld_pos(N_BL_BITS);
  localparam logic [N_BL_BITS-1:0] BL_MAX = N_BL_BITS'(N_BL - 1);

  state_t state_q, state_d;
  logic   restart, resync, accept;
  logic   at_boundary;

  logic [N_BL_BITS-1:0]    bl_q;
  logic [ACC_LEN_BITS-1:0] spec_q, acc_len_q, acc_len_eff, spec_last;

  assign acc_len_eff = (acc_len == '0) ? ACC_LEN_BITS'(1) : acc_len;
  assign spec_last   = acc_len_q - ACC_LEN_BITS'(1);
  assign at_boundary = (bl_q == '0) && (spec_q == '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sync) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    restart = 1'b0;
    resync  = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: restart = sync;
      RUN: begin
        restart = sync;
        resync  = sync && !at_boundary;
        accept  = in_valid && !sync;
      end
      default: ;
    endcase
  end

  // acc_len is re-latched only where an integration starts, so a change never splits one
  always_ff @(posedge clk) begin
    if (rst) begin
      bl_q      <= '0;
      spec_q    <= '0;
      acc_len_q <= ACC_LEN_BITS'(1);
    end else if (restart) begin
      bl_q      <= '0;
      spec_q    <= '0;
      acc_len_q <= acc_len_eff;
    end else if (accept) begin
      if (bl_q == BL_MAX) begin
        bl_q <= '0;
        if (spec_q == spec_last) begin
          spec_q    <= '0;
          acc_len_q <= acc_len_eff;
        end else begin
          spec_q <= spec_q + ACC_LEN_BITS'(1);
        end
      end else begin
        bl_q <= bl_q + N_BL_BITS'(1);
      end
    end
  end

  logic [TAG_W-1:0] tag_in, tag_q, tag_out;

  assign tag_in = {accept, bl_q, (spec_q == '0), (spec_q == spec_last)};

  // tag_q is the cycle the chain sees a/b; the delay line covers the chain itself
  always_ff @(posedge clk) begin
    if (rst) tag_q <= '0;
    else     tag_q <= tag_in;
  end

  xeng_tag_delay #(
    .N_BL_BITS(N_BL_BITS),
    .DEPTH    (MAC_LATENCY)
  ) u_tag_delay (
    .clk    (clk),
    .rst    (rst),
    .flush  (resync),
    .tag_in (tag_q),
    .tag_out(tag_out)
  );

  logic                 o_proc, o_first, o_last;
  logic [N_BL_BITS-1:0] o_bl;

  assign o_proc  = tag_out[TAG_VLD] && !resync;
  assign o_first = tag_out[TAG_FIRST_POS];
  assign o_last  = tag_out[TAG_LAST_POS];
  assign o_bl    = tag_out[TAG_BL_LSB +: N_BL_BITS];

  logic signed [OUTPUT_WIDTH-1:0] mac_re, mac_im;
  logic signed [ACC_WIDTH-1:0]    ext_re, ext_im, sum_re, sum_im;
  logic signed [ACC_WIDTH-1:0]    acc_re [N_BL];
  logic signed [ACC_WIDTH-1:0]    acc_im [N_BL];

  assign mac_re = mac_ab[2*OUTPUT_WIDTH-1:OUTPUT_WIDTH];
  assign mac_im = mac_ab[OUTPUT_WIDTH-1:0];
  assign ext_re = ACC_WIDTH'(mac_re);
  assign ext_im = ACC_WIDTH'(mac_im);
  assign sum_re = o_first ? ext_re : acc_re[o_bl] + ext_re;
  assign sum_im = o_first ? ext_im : acc_im[o_bl] + ext_im;

  // No reset needed: every integration's first tag overwrites its slot
  always_ff @(posedge clk) begin
    if (o_proc && !o_last) begin
      acc_re[o_bl] <= sum_re;
      acc_im[o_bl] <= sum_im;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout       <= '0;
      dout_bl    <= '0;
      sync_err   <= 1'b0;
    end else begin
      dout_valid <= o_proc && o_last;
      sync_err   <= resync;
      if (o_proc && o_last) begin
        dout    <= {sum_re, sum_im};
        dout_bl <= o_bl;
      end
    end
  end

  assign bl_idx  = bl_q;
  assign running = (state_q == RUN);

endmodule

// File: tb/tb_xeng_mac_ctrl.sv
// Scoreboard bench: a 32-bit and a 12-bit accumulator instance share one stimulus stream.
module tb_xeng_mac_ctrl;

  localparam int LAT = 6;
  localparam int OW  = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1, sync = 1'b0, in_valid = 1'b0;
  logic [7:0]  acc_len = 8'd0;
  logic [23:0] mac_ab = 24'd0;

  logic [1:0]  bl_idx, dout_bl, bl_idx12, dout_bl12;
  logic [63:0] dout;
  logic [23:0] dout12;
  logic        dout_valid, sync_err, running;
  logic        dout_valid12, sync_err12, running12;

  always #5 clk = ~clk;

  xeng_mac_ctrl #(.BITWIDTH(4), .N_INPUT_BITS(3), .N_BL_BITS(2), .ACC_LEN_BITS(8),
                  .ACC_WIDTH(32), .MAC_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .sync(sync), .acc_len(acc_len), .in_valid(in_valid),
    .bl_idx(bl_idx), .mac_ab(mac_ab), .dout(dout), .dout_valid(dout_valid),
    .dout_bl(dout_bl), .sync_err(sync_err), .running(running));

  xeng_mac_ctrl #(.BITWIDTH(4), .N_INPUT_BITS(3), .N_BL_BITS(2), .ACC_LEN_BITS(8),
                  .ACC_WIDTH(12), .MAC_LATENCY(LAT)) dut12 (
    .clk(clk), .rst(rst), .sync(sync), .acc_len(acc_len), .in_valid(in_valid),
    .bl_idx(bl_idx12), .mac_ab(mac_ab), .dout(dout12), .dout_valid(dout_valid12),
    .dout_bl(dout_bl12), .sync_err(sync_err12), .running(running12));

  int n_vec = 0, n_err = 0, edge_n = 0, t_acc = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {int bl; int re; int im; int cyc;} exp_t;
  exp_t q32[$], q12[$];
  exp_t e32, e12;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int wrap12(input int v);
    logic [11:0] t;
    t = v[11:0];
    return int'($signed(t));
  endfunction

  task automatic push_exp(input int bl, input int re, input int im, input int cyc);
    q32.push_back('{bl, re, im, cyc});
    q12.push_back('{bl, wrap12(re), wrap12(im), cyc});
  endtask

  task automatic set_mac(input int re, input int im);
    mac_ab = {12'(re), 12'(im)};
  endtask

  task automatic drive(input logic v, input logic s);
    in_valid = v;
    sync     = s;
    t_acc    = edge_n + 1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sync     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0);
  endtask

  // Starts at an integration boundary; the last spectrum of each integration is dumped
  task automatic run_spectra(input int acc_eff, input int nspec, input bit gap,
                             input int re, input int im);
    for (int s = 0; s < nspec; s++) begin
      for (int b = 0; b < 4; b++) begin
        chk("bl_idx", bl_idx, b);
        drive(1'b1, 1'b0);
        if ((s % acc_eff) == acc_eff - 1)
          push_exp(b, re * acc_eff, im * acc_eff, t_acc + LAT + 1);
        if (gap) drive(1'b0, 1'b0);
      end
    end
  endtask

  task automatic check_drained(input string tag);
    chk({tag, "_q32_left"}, q32.size(), 0);
    chk({tag, "_q12_left"}, q12.size(), 0);
    q32.delete();
    q12.delete();
  endtask

  always @(negedge clk) begin
    if (dout_valid) begin
      if (q32.size() == 0) chk("dout32_unexpected", 1, 0);
      else begin
        e32 = q32.pop_front();
        chk("dout32_bl", dout_bl, e32.bl);
        chk("dout32_re", $signed(dout[63:32]), e32.re);
        chk("dout32_im", $signed(dout[31:0]), e32.im);
        chk("dout32_cyc", edge_n, e32.cyc);
      end
    end
    if (dout_valid12) begin
      if (q12.size() == 0) chk("dout12_unexpected", 1, 0);
      else begin
        e12 = q12.pop_front();
        chk("dout12_bl", dout_bl12, e12.bl);
        chk("dout12_re", $signed(dout12[23:12]), e12.re);
        chk("dout12_im", $signed(dout12[11:0]), e12.im);
        chk("dout12_cyc", edge_n, e12.cyc);
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_running"}, running, 0);
    chk({tag, "_dout_valid"}, dout_valid, 0);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_dout_bl"}, dout_bl, 0);
    chk({tag, "_bl_idx"}, bl_idx, 0);
    chk({tag, "_sync_err"}, sync_err, 0);
    chk({tag, "_running12"}, running12, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;

    // acc_len=2, continuous accepts
    acc_len = 8'd2;
    set_mac(3, -1);
    drive(1'b0, 1'b1);
    chk("running_after_sync", running, 1);
    run_spectra(2, 2, 1'b0, 3, -1);
    idle(12);
    check_drained("cont");

    // same with in_valid toggling; sync lands on a boundary
    drive(1'b0, 1'b1);
    chk("sync_err_boundary", sync_err, 0);
    run_spectra(2, 2, 1'b1, 3, -1);
    idle(12);
    check_drained("gap");

    // acc_len=0 acts as 1
    acc_len = 8'd0;
    set_mac(-5, 7);
    drive(1'b0, 1'b1);
    chk("sync_err_len0", sync_err, 0);
    run_spectra(1, 1, 1'b0, -5, 7);
    idle(12);
    check_drained("len0");

    // resync at spec=1, bl=2
    acc_len = 8'd4;
    set_mac(3, -1);
    drive(1'b0, 1'b1);
    chk("sync_err_len4", sync_err, 0);
    for (int k = 0; k < 6; k++) begin
      chk("bl_idx_pre", bl_idx, k % 4);
      drive(1'b1, 1'b0);
    end
    drive(1'b0, 1'b1);
    chk("sync_err_resync", sync_err, 1);
    chk("bl_idx_resync", bl_idx, 0);
    drive(1'b0, 1'b0);
    chk("sync_err_pulse", sync_err, 0);
    run_spectra(4, 4, 1'b0, 3, -1);
    idle(12);
    check_drained("resync");

    // resync must drop in-flight last tags
    acc_len = 8'd1;
    drive(1'b0, 1'b1);
    chk("sync_err_len1", sync_err, 0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    chk("sync_err_flush", sync_err, 1);
    idle(12);
    check_drained("flush");

    // rst mid-run with tags in flight
    drive(1'b0, 1'b1);
    repeat (3) drive(1'b1, 1'b0);
    rst = 1'b1;
    drive(1'b1, 1'b0);
    check_zero_outputs("midrst");
    rst = 1'b0;
    repeat (5) drive(1'b1, 1'b0);
    chk("bl_idx_idle", bl_idx, 0);
    chk("running_idle", running, 0);
    idle(12);
    check_drained("midrst");

    // wrap in the 12-bit accumulator
    acc_len = 8'd3;
    set_mac(2047, -2048);
    drive(1'b0, 1'b1);
    chk("running_wrap", running, 1);
    run_spectra(3, 3, 1'b0, 2047, -2048);
    idle(12);
    check_drained("wrap");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
